eth_rx_mac_filter: RTL and testbench

- 8-bit AXI-Stream receive filter that sits directly downstream of the tri-mode AXI Ethernet MAC RX interface and upstream of the LegoFPGA datapath.
- Buffers each frame's 6-byte destination MAC, then forwards or drops the whole frame:
  - unicast match to the local address: forward;
  - broadcast: forward when enabled;
  - multicast: forward when enabled;
  - promiscuous mode: forward everything.
- Keeps saturating forwarded/dropped frame counters for debug LEDs and ILA.

---
 rtl/eth_rx_mac_filter_if.sv | 19 +
 rtl/eth_rx_mac_filter.sv | 192 +++++++++++++++++++
 tb/tb_eth_rx_mac_filter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_mac_filter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : eth_rx_mac_filter_if
// Brief    : 8-bit AXI-Stream bundle (data, valid, last, user, ready) with
//            master/slave views for the RX MAC address filter.
// Revision : 1.0 - initial release
// ============================================================================
interface eth_rx_mac_filter_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tlast;
   logic       tuser;
   logic       tready;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/eth_rx_mac_filter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : eth_rx_mac_filter
// Brief    : Buffers the 6-byte destination MAC of each received frame, then
//            replays and forwards the frame or discards it. Keeps saturating
//            forwarded / dropped frame counters.
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_mac_filter #(
   parameter logic [47:0] LOCAL_MAC    = 48'h000A35000001,
   parameter bit          ACCEPT_BCAST = 1'b1,
   parameter bit          ACCEPT_MCAST = 1'b0,
   parameter int          CNT_W        = 32
) (
   input  logic                 clk_125,
   input  logic                 sys_rst_n,
   input  logic                 promisc,
   eth_rx_mac_filter_if.slave   s_axis,
   eth_rx_mac_filter_if.master  m_axis,
   output logic [CNT_W-1:0]     frames_ok,
   output logic [CNT_W-1:0]     frames_drop,
   output logic                 filter_busy
);

   localparam logic [47:0]      c_bcast_mac = {48{1'b1}};
   localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR    = 3'd1,
      S_REPLAY = 3'd2,
      S_PASS   = 3'd3,
      S_DROP   = 3'd4
   } state_t;

   state_t           r_state;
   logic [1:0]       r_rst_sync;
   logic [7:0]       r_hdr [0:5];
   logic [2:0]       r_idx;
   logic [2:0]       r_rptr;
   logic [7:0]       r_m_tdata;
   logic             r_m_tvalid;
   logic             r_m_tlast;
   logic             r_m_tuser;
   logic [CNT_W-1:0] r_frames_ok;
   logic [CNT_W-1:0] r_frames_drop;

   logic             w_rst_n;
   logic             w_s_tready;
   logic             w_s_fire;
   logic             w_m_fire;
   logic [47:0]      w_dest;
   logic             w_match;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + c_cnt_one;
   endfunction

   // Reset synchronizer: asserts immediately, releases two clocks after sys_rst_n rises.
   always_ff @(posedge clk_125 or negedge sys_rst_n) begin
      if (!sys_rst_n) r_rst_sync <= 2'b00;
      else            r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   // Destination address as it stands once the 6th byte arrives (5 stored + live byte).
   assign w_dest  = {r_hdr[0], r_hdr[1], r_hdr[2], r_hdr[3], r_hdr[4], s_axis.tdata};
   assign w_match = promisc
                  | (w_dest == LOCAL_MAC)
                  | (ACCEPT_BCAST & (w_dest == c_bcast_mac))
                  | (ACCEPT_MCAST & w_dest[40] & (w_dest != c_bcast_mac));

   // Input ready per state; in PASS the input is also held off once the tlast
   // beat sits in the output register so the next frame's first byte is not
   // swallowed into this frame.
   always_comb begin
      w_s_tready = 1'b0;
      if (w_rst_n) begin
         case (r_state)
            S_IDLE, S_HDR, S_DROP: w_s_tready = 1'b1;
            S_PASS:  w_s_tready = !(r_m_tvalid & r_m_tlast) & (!r_m_tvalid | m_axis.tready);
            default: w_s_tready = 1'b0;
         endcase
      end
   end

   assign w_s_fire = s_axis.tvalid & w_s_tready;
   assign w_m_fire = r_m_tvalid & m_axis.tready;

   // Frame state machine: header capture, decision, header replay, pass-through and drop.
   always_ff @(posedge clk_125 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state       <= S_IDLE;
         r_idx         <= 3'd0;
         r_rptr        <= 3'd0;
         r_m_tdata     <= 8'd0;
         r_m_tvalid    <= 1'b0;
         r_m_tlast     <= 1'b0;
         r_m_tuser     <= 1'b0;
         r_frames_ok   <= '0;
         r_frames_drop <= '0;
         for (int i = 0; i < 6; i++) r_hdr[i] <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_s_fire) begin
                  r_hdr[0] <= s_axis.tdata;
                  if (s_axis.tlast) begin
                     r_frames_drop <= sat_inc(r_frames_drop);
                  end else begin
                     r_idx   <= 3'd1;
                     r_state <= S_HDR;
                  end
               end
            end
            S_HDR: begin
               if (w_s_fire) begin
                  r_hdr[r_idx] <= s_axis.tdata;
                  if (s_axis.tlast) begin
                     // Frames of 6 bytes or fewer carry no payload: runt.
                     r_frames_drop <= sat_inc(r_frames_drop);
                     r_idx         <= 3'd0;
                     r_state       <= S_IDLE;
                  end else if (r_idx == 3'd5) begin
                     r_idx <= 3'd0;
                     if (w_match) begin
                        r_m_tdata  <= r_hdr[0];
                        r_m_tvalid <= 1'b1;
                        r_m_tlast  <= 1'b0;
                        r_m_tuser  <= 1'b0;
                        r_rptr     <= 3'd1;
                        r_state    <= S_REPLAY;
                     end else begin
                        r_state    <= S_DROP;
                     end
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end
            end
            S_REPLAY: begin
               // r_rptr names the next header byte to present; 6 means hdr[5] is on the bus.
               if (w_m_fire) begin
                  if (r_rptr == 3'd6) begin
                     r_m_tvalid <= 1'b0;
                     r_rptr     <= 3'd0;
                     r_state    <= S_PASS;
                  end else begin
                     r_m_tdata <= r_hdr[r_rptr];
                     r_rptr    <= r_rptr + 3'd1;
                  end
               end
            end
            S_PASS: begin
               if (w_s_fire) begin
                  r_m_tdata  <= s_axis.tdata;
                  r_m_tvalid <= 1'b1;
                  r_m_tlast  <= s_axis.tlast;
                  r_m_tuser  <= s_axis.tuser & s_axis.tlast;
               end else if (w_m_fire) begin
                  r_m_tvalid <= 1'b0;
                  if (r_m_tlast) begin
                     r_m_tlast   <= 1'b0;
                     r_m_tuser   <= 1'b0;
                     r_frames_ok <= sat_inc(r_frames_ok);
                     r_state     <= S_IDLE;
                  end
               end
            end
            S_DROP: begin
               if (w_s_fire && s_axis.tlast) begin
                  r_frames_drop <= sat_inc(r_frames_drop);
                  r_state       <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_axis.tready = w_s_tready;
   assign m_axis.tdata  = r_m_tdata;
   assign m_axis.tvalid = r_m_tvalid;
   assign m_axis.tlast  = r_m_tlast;
   assign m_axis.tuser  = r_m_tuser;
   assign frames_ok     = r_frames_ok;
   assign frames_drop   = r_frames_drop;
   assign filter_busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_mac_filter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_eth_rx_mac_filter
// Brief    : Self-checking bench for eth_rx_mac_filter. A frame-level model
//            decides forward/drop from the destination address and predicts
//            the output beat stream and the saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_rx_mac_filter;

   localparam int          CW    = 4;
   localparam logic [47:0] LMAC  = 48'h000A35000001;
   localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
   localparam int          CMAX  = (1 << CW) - 1;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          promisc = 1'b0;
   logic [CW-1:0] frames_ok;
   logic [CW-1:0] frames_drop;
   logic          filter_busy;

   eth_rx_mac_filter_if s_if();
   eth_rx_mac_filter_if m_if();

   eth_rx_mac_filter #(.CNT_W(CW)) dut (
      .clk_125     (clk),
      .sys_rst_n   (rst_n),
      .promisc     (promisc),
      .s_axis      (s_if),
      .m_axis      (m_if),
      .frames_ok   (frames_ok),
      .frames_drop (frames_drop),
      .filter_busy (filter_busy)
   );

   always #4 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Cycle counter for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready pattern: 0 = always ready, 1 = toggle with a periodic 10-cycle stall, 2 = random.
   int rdy_mode  = 0;
   int burst_cnt = 0;
   int burst_left = 0;
   initial m_if.tready = 1'b1;
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0) begin
         m_if.tready = 1'b1;
      end else if (rdy_mode == 1) begin
         burst_cnt = burst_cnt + 1;
         if (burst_cnt % 40 == 20) burst_left = 10;
         if (burst_left > 0) begin
            m_if.tready = 1'b0;
            burst_left  = burst_left - 1;
         end else begin
            m_if.tready = ~m_if.tready;
         end
      end else begin
         m_if.tready = ($urandom_range(0, 3) != 0);
      end
   end

   // Output monitor: records accepted beats as {tuser,tlast,tdata} and
   // counts any change of a stalled beat.
   logic [9:0] rx_q[$];
   int         stab_err      = 0;
   bit         hold_pend     = 1'b0;
   logic [9:0] held          = '0;
   int         first_out_cyc = -1;
   always @(negedge clk) begin
      if (hold_pend && !(m_if.tvalid === 1'b1 && {m_if.tuser, m_if.tlast, m_if.tdata} === held))
         stab_err = stab_err + 1;
      hold_pend = (m_if.tvalid === 1'b1) && (m_if.tready === 1'b0);
      held      = {m_if.tuser, m_if.tlast, m_if.tdata};
      if (m_if.tvalid === 1'b1 && first_out_cyc < 0) first_out_cyc = cyc;
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1)
         rx_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
   end

   // ---------------- reference model ----------------
   logic [7:0] fr[$];
   logic       fr_user;
   logic [9:0] exp_q[$];
   int         exp_ok   = 0;
   int         exp_drop = 0;
   int         acc6_cyc = -1;

   function automatic int sat(input int v);
      return (v < CMAX) ? v + 1 : v;
   endfunction

   // Frame-level rule: a frame needs at least one byte beyond the address to
   // be considered; it is forwarded on exact station match, broadcast, or in
   // promiscuous mode (multicast acceptance is disabled in this build).
   task automatic model_frame(input bit pm);
      bit          fwd;
      logic [47:0] d;
      fwd = 1'b0;
      if (fr.size() > 6) begin
         d   = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
         fwd = pm || (d == LMAC) || (d == BCAST);
      end
      if (fwd) begin
         for (int i = 0; i < fr.size(); i++) begin
            bit lst;
            lst = (i == fr.size() - 1);
            exp_q.push_back({lst ? fr_user : 1'b0, lst, fr[i]});
         end
         exp_ok = sat(exp_ok);
      end else begin
         exp_drop = sat(exp_drop);
      end
   endtask

   task automatic build_frame(input logic [47:0] dest, input int len);
      fr.delete();
      for (int i = 0; i < len; i++)
         fr.push_back(i < 6 ? dest[47 - 8*i -: 8] : 8'($urandom));
   endtask

   task automatic send_frame(input int gap_pct);
      bit acc;
      int guard;
      for (int i = 0; i < fr.size(); i++) begin
         while ($urandom_range(0, 99) < gap_pct) begin
            s_if.tvalid = 1'b0;
            @(posedge clk); #1;
         end
         s_if.tvalid = 1'b1;
         s_if.tdata  = fr[i];
         s_if.tlast  = (i == fr.size() - 1);
         s_if.tuser  = s_if.tlast ? fr_user : 1'($urandom_range(0, 1));
         acc   = 1'b0;
         guard = 0;
         while (!acc) begin
            @(negedge clk);
            acc = (s_if.tready === 1'b1);
            if (acc && i == 5) acc6_cyc = cyc;
            @(posedge clk); #1;
            guard = guard + 1;
            if (guard > 1000) begin
               checks   = checks + 1;
               failures = failures + 1;
               $display("FAIL send_timeout: byte %0d not accepted, tready=%b expected 1", i, s_if.tready);
               s_if.tvalid = 1'b0;
               return;
            end
         end
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
   endtask

   task automatic wait_drain(output bit timed_out);
      timed_out = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (filter_busy === 1'b0 && m_if.tvalid === 1'b0) begin
            timed_out = 1'b0;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   function automatic int first_diff();
      int n;
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) return i;
      if (rx_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   function automatic string stream_msg(input int d);
      logic [9:0] g, e;
      g = (d < rx_q.size())  ? rx_q[d]  : 10'h3FF;
      e = (d < exp_q.size()) ? exp_q[d] : 10'h3FF;
      return $sformatf("beat %0d got %03h expected %03h (beats got %0d expected %0d)",
                       d, g, e, rx_q.size(), exp_q.size());
   endfunction

   function automatic void clear_streams();
      rx_q.delete();
      exp_q.delete();
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0; s_if.tdata = 8'd0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks = checks + 6;
      if (s_if.tready !== 1'b0) begin failures++; $display("FAIL rst_tready: got %b expected 0", s_if.tready); end
      if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b expected 0", m_if.tvalid); end
      if ({m_if.tdata, m_if.tlast, m_if.tuser} !== 10'd0) begin failures++; $display("FAIL rst_mdata: got %h expected 0", {m_if.tdata, m_if.tlast, m_if.tuser}); end
      if (frames_ok !== '0) begin failures++; $display("FAIL rst_ok: got %0d expected 0", frames_ok); end
      if (frames_drop !== '0) begin failures++; $display("FAIL rst_drop: got %0d expected 0", frames_drop); end
      if (filter_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", filter_busy); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks = checks + 1;
      if (s_if.tready !== 1'b1) begin failures++; $display("FAIL idle_tready: got %b expected 1", s_if.tready); end
      @(posedge clk); #1;
   endtask

   task automatic test_unicast();
      bit to;
      rdy_mode = 0; promisc = 1'b0; fr_user = 1'b0;
      build_frame(LMAC, 64);
      model_frame(promisc);
      first_out_cyc = -1; acc6_cyc = -1;
      send_frame(0);
      wait_drain(to);
      checks = checks + 5;
      if (to !== 1'b0) begin failures++; $display("FAIL uni_drain: timed_out=%b expected 0", to); end
      if (first_diff() != -1) begin failures++; $display("FAIL uni_stream: %s", stream_msg(first_diff())); end
      if (first_out_cyc != acc6_cyc + 1) begin failures++; $display("FAIL uni_latency: first out cycle %0d expected %0d", first_out_cyc, acc6_cyc + 1); end
      if (frames_ok !== exp_ok[CW-1:0]) begin failures++; $display("FAIL uni_ok: got %0d expected %0d", frames_ok, exp_ok); end
      if (frames_drop !== exp_drop[CW-1:0]) begin failures++; $display("FAIL uni_drop: got %0d expected %0d", frames_drop, exp_drop); end
      clear_streams();
   endtask

   task automatic test_filter();
      bit to;
      rdy_mode = 0; fr_user = 1'b0;
      for (int pm = 0; pm < 2; pm++) begin
         promisc = 1'(pm);
         build_frame(48'h001122334455, 20);
         model_frame(promisc);
         first_out_cyc = -1;
         send_frame(10);
         wait_drain(to);
         checks = checks + 4;
         if (to !== 1'b0) begin failures++; $display("FAIL filt_drain%0d: timed_out=%b expected 0", pm, to); end
         if (first_diff() != -1) begin failures++; $display("FAIL filt_stream%0d: %s", pm, stream_msg(first_diff())); end
         if (frames_ok !== exp_ok[CW-1:0]) begin failures++; $display("FAIL filt_ok%0d: got %0d expected %0d", pm, frames_ok, exp_ok); end
         if (frames_drop !== exp_drop[CW-1:0]) begin failures++; $display("FAIL filt_drop%0d: got %0d expected %0d", pm, frames_drop, exp_drop); end
         if (pm == 0) begin
            checks = checks + 1;
            if (first_out_cyc != -1) begin failures++; $display("FAIL filt_novalid: tvalid seen at cycle %0d expected none", first_out_cyc); end
         end
         clear_streams();
      end
      promisc = 1'b0;
   endtask

   task automatic test_bcast_mcast();
      bit to;
      rdy_mode = 0; promisc = 1'b0; fr_user = 1'b0;
      build_frame(BCAST, 30);
      model_frame(promisc);
      send_frame(0);
      build_frame(48'h01005E000001, 30);
      model_frame(promisc);
      send_frame(0);
      wait_drain(to);
      checks = checks + 4;
      if (to !== 1'b0) begin failures++; $display("FAIL bm_drain: timed_out=%b expected 0", to); end
      if (first_diff() != -1) begin failures++; $display("FAIL bm_stream: %s", stream_msg(first_diff())); end
      if (frames_ok !== exp_ok[CW-1:0]) begin failures++; $display("FAIL bm_ok: got %0d expected %0d", frames_ok, exp_ok); end
      if (frames_drop !== exp_drop[CW-1:0]) begin failures++; $display("FAIL bm_drop: got %0d expected %0d", frames_drop, exp_drop); end
      clear_streams();
   endtask

   task automatic test_runt();
      bit to;
      int lens[3] = '{4, 6, 1};
      rdy_mode = 0; promisc = 1'b0; fr_user = 1'b0;
      foreach (lens[k]) begin
         build_frame(LMAC, lens[k]);
         model_frame(promisc);
         send_frame(0);
         @(negedge clk);
         checks = checks + 2;
         if (filter_busy !== 1'b0) begin failures++; $display("FAIL runt_idle%0d: busy=%b expected 0", lens[k], filter_busy); end
         if (frames_drop !== exp_drop[CW-1:0]) begin failures++; $display("FAIL runt_drop%0d: got %0d expected %0d", lens[k], frames_drop, exp_drop); end
         @(posedge clk); #1;
      end
      build_frame(LMAC, 20);
      model_frame(promisc);
      send_frame(0);
      wait_drain(to);
      checks = checks + 3;
      if (to !== 1'b0) begin failures++; $display("FAIL runt_drain: timed_out=%b expected 0", to); end
      if (first_diff() != -1) begin failures++; $display("FAIL runt_follow: %s", stream_msg(first_diff())); end
      if (frames_ok !== exp_ok[CW-1:0]) begin failures++; $display("FAIL runt_ok: got %0d expected %0d", frames_ok, exp_ok); end
      clear_streams();
   endtask

   task automatic test_backpressure();
      bit to;
      promisc = 1'b0; fr_user = 1'b0;
      stab_err = 0; burst_cnt = 0; burst_left = 0;
      rdy_mode = 1;
      build_frame(LMAC, 100);
      model_frame(promisc);
      send_frame(0);
      wait_drain(to);
      rdy_mode = 0;
      checks = checks + 4;
      if (to !== 1'b0) begin failures++; $display("FAIL bp_drain: timed_out=%b expected 0", to); end
      if (first_diff() != -1) begin failures++; $display("FAIL bp_stream: %s", stream_msg(first_diff())); end
      if (stab_err != 0) begin failures++; $display("FAIL bp_stable: %0d stalled beats changed, expected 0", stab_err); end
      if (frames_ok !== exp_ok[CW-1:0]) begin failures++; $display("FAIL bp_ok: got %0d expected %0d", frames_ok, exp_ok); end
      clear_streams();
   endtask

   task automatic test_tuser();
      bit to;
      rdy_mode = 0; promisc = 1'b0; fr_user = 1'b1;
      build_frame(LMAC, 25);
      model_frame(promisc);
      send_frame(20);
      wait_drain(to);
      fr_user = 1'b0;
      checks = checks + 3;
      if (to !== 1'b0) begin failures++; $display("FAIL tuser_drain: timed_out=%b expected 0", to); end
      if (first_diff() != -1) begin failures++; $display("FAIL tuser_stream: %s", stream_msg(first_diff())); end
      if (frames_ok !== exp_ok[CW-1:0]) begin failures++; $display("FAIL tuser_ok: got %0d expected %0d", frames_ok, exp_ok); end
      clear_streams();
   endtask

   task automatic test_back_to_back();
      bit to;
      logic [47:0] d;
      stab_err = 0;
      rdy_mode = 2;
      for (int f = 0; f < 40; f++) begin
         case ($urandom_range(0, 4))
            0: d = LMAC;
            1: d = BCAST;
            2: d = {8'($urandom) | 8'h01, 40'($urandom) << 8 | 40'($urandom)};
            3: d = {8'($urandom) & 8'hFE, 40'($urandom) << 8 | 40'($urandom)};
            default: d = LMAC ^ (48'd1 << $urandom_range(0, 47));
         endcase
         promisc = ($urandom_range(0, 3) == 0);
         fr_user = 1'($urandom_range(0, 1));
         build_frame(d, $urandom_range(1, 30));
         model_frame(promisc);
         send_frame(($urandom_range(0, 1) == 0) ? 0 : 30);
      end
      wait_drain(to);
      rdy_mode = 0; promisc = 1'b0; fr_user = 1'b0;
      checks = checks + 5;
      if (to !== 1'b0) begin failures++; $display("FAIL b2b_drain: timed_out=%b expected 0", to); end
      if (first_diff() != -1) begin failures++; $display("FAIL b2b_stream: %s", stream_msg(first_diff())); end
      if (stab_err != 0) begin failures++; $display("FAIL b2b_stable: %0d stalled beats changed, expected 0", stab_err); end
      if (frames_ok !== exp_ok[CW-1:0]) begin failures++; $display("FAIL b2b_ok: got %0d expected %0d", frames_ok, exp_ok); end
      if (frames_drop !== exp_drop[CW-1:0]) begin failures++; $display("FAIL b2b_drop: got %0d expected %0d", frames_drop, exp_drop); end
      clear_streams();
   endtask

   task automatic test_saturation();
      bit to;
      rdy_mode = 0; promisc = 1'b0; fr_user = 1'b0;
      for (int f = 0; f < CMAX + 2; f++) begin
         build_frame(LMAC, 8);
         model_frame(promisc);
         send_frame(0);
         build_frame(LMAC, 3);
         model_frame(promisc);
         send_frame(0);
      end
      wait_drain(to);
      checks = checks + 5;
      if (to !== 1'b0) begin failures++; $display("FAIL sat_drain: timed_out=%b expected 0", to); end
      if (first_diff() != -1) begin failures++; $display("FAIL sat_stream: %s", stream_msg(first_diff())); end
      if (frames_ok !== exp_ok[CW-1:0]) begin failures++; $display("FAIL sat_ok_model: got %0d expected %0d", frames_ok, exp_ok); end
      if (frames_ok !== {CW{1'b1}}) begin failures++; $display("FAIL sat_ok_max: got %0d expected %0d", frames_ok, CMAX); end
      if (frames_drop !== {CW{1'b1}}) begin failures++; $display("FAIL sat_drop_max: got %0d expected %0d", frames_drop, CMAX); end
      clear_streams();
   endtask

   initial begin
      test_reset();
      test_unicast();
      test_filter();
      test_bcast_mcast();
      test_runt();
      test_backpressure();
      test_tuser();
      test_back_to_back();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
